branch_resolve_unit: RTL and testbench

Pipelined, parametrised branch resolution unit for the execute stage. It evaluates the RV32/RV64 conditional-branch comparisons with the 3-bit branch function encoding used across the core, plus an unconditional-jump code. It computes the branch target and fall-through address, and checks the result against the front-end prediction. Results leave through a valid/ready stream after a configurable number of register stages, with flush support and a saturating mispredict counter for performance monitoring.

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/branch_resolve_unit_if.sv | 40 ++++
 rtl/branch_resolve_unit_cond_eval.sv | 58 +++++
 rtl/branch_resolve_unit.sv | 94 +++++++++
 tb/tb_branch_resolve_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution unit.
// Holds the 3-bit branch function codes used across the core and the
// payload carried by each pipeline stage. The payload PC field is sized for
// the widest supported XLEN; narrower configurations use the low bits only.
package branch_resolve_unit_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [2:0] BR_BEQ     = 3'b000;
    localparam logic [2:0] BR_BNE     = 3'b001;
    localparam logic [2:0] BR_BLT     = 3'b010;
    localparam logic [2:0] BR_BGE     = 3'b011;
    localparam logic [2:0] BR_BLTU    = 3'b100;
    localparam logic [2:0] BR_BGEU    = 3'b101;
    localparam logic [2:0] BR_JUMP    = 3'b110;
    localparam logic [2:0] BR_ILLEGAL = 3'b111;

    typedef struct packed {
        logic                taken;
        logic [MAX_XLEN-1:0] redirect_pc;
        logic                mispredict;
        logic                illegal;
    } br_payload_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result stream bundle for the branch resolution unit.
// master: the execute-stage driver (issues requests, flush, out_ready).
// slave : the unit itself (returns in_ready, results and the counter).
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [2:0]       in_func;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_redirect_pc;
    logic             out_mispredict;
    logic             out_illegal;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output in_valid, in_a, in_b, in_func, in_pc, in_imm,
               in_pred_taken, in_pred_target, flush, out_ready,
        input  in_ready, out_valid, out_taken, out_redirect_pc,
               out_mispredict, out_illegal, mispredict_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_func, in_pc, in_imm,
               in_pred_taken, in_pred_target, flush, out_ready,
        output in_ready, out_valid, out_taken, out_redirect_pc,
               out_mispredict, out_illegal, mispredict_cnt
    );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// branch_cond_eval: purely combinational branch evaluation.
// Inputs : a_i/b_i operands, func_i branch code, pc_i/imm_i address fields,
//          pred_taken_i/pred_target_i front-end prediction.
// Output : result_o payload (taken, redirect PC, mispredict, illegal).
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      func_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output br_payload_t     result_o
);

    logic            taken;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallThrough;
    logic [XLEN-1:0] redirect;
    logic            mispredict;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func_i)
            BR_BEQ:  taken = (a_i == b_i);
            BR_BNE:  taken = (a_i != b_i);
            BR_BLT:  taken = ($signed(a_i) <  $signed(b_i));
            BR_BGE:  taken = ($signed(a_i) >= $signed(b_i));
            BR_BLTU: taken = (a_i <  b_i);
            BR_BGEU: taken = (a_i >= b_i);
            BR_JUMP: taken = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Both sums wrap naturally at XLEN bits.
    assign target      = pc_i + imm_i;
    assign fallThrough = pc_i + XLEN'(4);
    assign redirect    = taken ? target : fallThrough;

    // Illegal ops never request a redirect; the predicted target only
    // matters when both sides agree the branch is taken.
    assign mispredict = !illegal &&
                        ((taken != pred_taken_i) ||
                         (taken && pred_taken_i && (target != pred_target_i)));

    assign result_o.taken       = taken;
    assign result_o.redirect_pc = MAX_XLEN'(redirect);
    assign result_o.mispredict  = mispredict;
    assign result_o.illegal     = illegal;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined branch resolution for the execute stage.
// Ports: clk, rst_n (async, active-low), bus (slave side of
// branch_resolve_unit_if carrying the request/result streams, flush and
// the saturating mispredict counter).
// STAGES (1 or 2) register stages sit between request and result.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus
);

    localparam int LAST = STAGES - 1;

    br_payload_t       evalResult;
    br_payload_t       payload_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic              lastAdvance;
    logic              firstAdvance;
    logic              accept;
    logic              deliverMispredict;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    branch_cond_eval #(.XLEN(XLEN)) u_eval (
        .a_i           (bus.in_a),
        .b_i           (bus.in_b),
        .func_i        (bus.in_func),
        .pc_i          (bus.in_pc),
        .imm_i         (bus.in_imm),
        .pred_taken_i  (bus.in_pred_taken),
        .pred_target_i (bus.in_pred_target),
        .result_o      (evalResult)
    );

    // A stage may load when it is empty or its contents move on this edge.
    assign lastAdvance  = !valid_q[LAST] || bus.out_ready;
    assign firstAdvance = (STAGES == 1) ? lastAdvance
                                        : (!valid_q[0] || lastAdvance);

    assign bus.in_ready = !bus.flush && firstAdvance;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else begin
            if (firstAdvance) valid_q[0] <= accept;
            if (STAGES > 1 && lastAdvance) valid_q[LAST] <= valid_q[0];
        end
    end

    // Payload is left unreset; outputs are gated by the valid bit instead.
    always_ff @(posedge clk) begin
        if (firstAdvance) payload_q[0] <= evalResult;
        if (STAGES > 1 && lastAdvance) payload_q[LAST] <= payload_q[0];
    end

    // A result shown during flush is discarded, so it is not counted.
    assign deliverMispredict = valid_q[LAST] && bus.out_ready &&
                               payload_q[LAST].mispredict && !bus.flush;
    assign cnt_d = (deliverMispredict && (cnt_q != '1)) ? cnt_q + CNT_W'(1)
                                                         : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_valid       = valid_q[LAST];
    assign bus.out_taken       = valid_q[LAST] && payload_q[LAST].taken;
    assign bus.out_mispredict  = valid_q[LAST] && payload_q[LAST].mispredict;
    assign bus.out_illegal     = valid_q[LAST] && payload_q[LAST].illegal;
    assign bus.out_redirect_pc = valid_q[LAST] ? payload_q[LAST].redirect_pc[XLEN-1:0]
                                               : '0;
    assign bus.mispredict_cnt  = cnt_q;

    // Upper PC bits are always zero for narrow XLEN and are dropped here.
    if (XLEN < MAX_XLEN) begin : g_narrow
        logic unusedUpperBits;
        assign unusedUpperBits = ^payload_q[LAST].redirect_pc[MAX_XLEN-1:XLEN];
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// dut2 is the main target (XLEN=32, STAGES=2, CNT_W=2); dut1 (STAGES=1,
// CNT_W=16) covers single-stage latency and a wide counter.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  b2 ();
    branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) b1 ();

    branch_resolve_unit #(.XLEN(32), .STAGES(2), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    branch_resolve_unit #(.XLEN(32), .STAGES(1), .CNT_W(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Quiet all request inputs on both units and allow results to drain.
    task automatic idleInputs();
        b2.in_valid = 0; b2.in_a = 0; b2.in_b = 0; b2.in_func = 0;
        b2.in_pc = 0; b2.in_imm = 0; b2.in_pred_taken = 0;
        b2.in_pred_target = 0; b2.flush = 0; b2.out_ready = 1;
        b1.in_valid = 0; b1.in_a = 0; b1.in_b = 0; b1.in_func = 0;
        b1.in_pc = 0; b1.in_imm = 0; b1.in_pred_taken = 0;
        b1.in_pred_target = 0; b1.flush = 0; b1.out_ready = 1;
    endtask

    // Present one request on dut2 without waiting for acceptance.
    task automatic setReq(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] func, input logic [31:0] pc,
                          input logic [31:0] imm, input logic predTaken,
                          input logic [31:0] predTarget);
        b2.in_a = a; b2.in_b = b; b2.in_func = func; b2.in_pc = pc;
        b2.in_imm = imm; b2.in_pred_taken = predTaken;
        b2.in_pred_target = predTarget; b2.in_valid = 1;
    endtask

    // Present a request on dut2 and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] func, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic predTaken,
                                 input logic [31:0] predTarget,
                                 output bit accepted);
        setReq(a, b, func, pc, imm, predTaken, predTarget);
        accepted = 0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            accepted = b2.in_ready;
            @(posedge clk); #1;
        end
        b2.in_valid = 0;
    endtask

    // Wait (bounded) for dut2 to present a result.
    task automatic waitOutValid(output bit seen);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (b2.out_valid) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic doReset();
        b2.in_valid = 0;
        b1.in_valid = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (b2.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", b2.out_valid);
        else passCount++;
        checkCount++;
        if (b2.mispredict_cnt !== 2'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", b2.mispredict_cnt);
        else passCount++;
        checkCount++;
        if ({b2.out_redirect_pc, b2.out_taken, b2.out_mispredict, b2.out_illegal} !== 35'd0)
            $display("[TB] FAIL reset_payload_gated: got %h/%b%b%b expected 0", b2.out_redirect_pc,
                     b2.out_taken, b2.out_mispredict, b2.out_illegal);
        else passCount++;
        checkCount++;
        if (b1.out_valid !== 1'b0) $display("[TB] FAIL reset_s1_out_valid: got %b expected 0", b1.out_valid);
        else passCount++;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_stage1();
        b1.in_a = 32'd7; b1.in_b = 32'd7; b1.in_func = 3'b000; b1.in_pc = 32'h40;
        b1.in_imm = 32'h8; b1.in_pred_taken = 1; b1.in_pred_target = 32'h48;
        b1.in_valid = 1;
        #1;
        checkCount++;
        if (b1.in_ready !== 1'b1) $display("[TB] FAIL s1_in_ready: got %b expected 1", b1.in_ready);
        else passCount++;
        @(posedge clk); #1;
        b1.in_valid = 0;
        checkCount++;
        if (b1.out_valid !== 1'b1) $display("[TB] FAIL s1_latency: got %b expected 1", b1.out_valid);
        else passCount++;
        checkCount++;
        if (b1.out_redirect_pc !== 32'h48) $display("[TB] FAIL s1_redirect: got %h expected 00000048", b1.out_redirect_pc);
        else passCount++;
        checkCount++;
        if ({b1.out_taken, b1.out_mispredict, b1.out_illegal} !== 3'b100)
            $display("[TB] FAIL s1_flags: got %b%b%b expected 100", b1.out_taken, b1.out_mispredict, b1.out_illegal);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (b1.out_valid !== 1'b0) $display("[TB] FAIL s1_drain: got %b expected 0", b1.out_valid);
        else passCount++;
        b1.in_b = 32'd8;
        b1.in_valid = 1;
        @(posedge clk); #1;
        b1.in_valid = 0;
        checkCount++;
        if ({b1.out_valid, b1.out_taken, b1.out_mispredict, b1.out_redirect_pc} !== {3'b101, 32'h44})
            $display("[TB] FAIL s1_mispredict: got %b%b%b/%h expected 101/00000044", b1.out_valid,
                     b1.out_taken, b1.out_mispredict, b1.out_redirect_pc);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (b1.mispredict_cnt !== 16'd1) $display("[TB] FAIL s1_cnt: got %0d expected 1", b1.mispredict_cnt);
        else passCount++;
    endtask

    task automatic test_compare();
        logic [31:0] vecA [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        logic [31:0] vecB [10] = '{32'd1, 32'd1, 32'd1, 32'd1,
                                   32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        logic [2:0]  vecFunc [10] = '{3'b010, 3'b100, 3'b011, 3'b101, 3'b000,
                                      3'b001, 3'b011, 3'b101, 3'b111, 3'b010};
        logic        vecPred [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [2:0]  vecFlags [10] = '{3'b110, 3'b000, 3'b000, 3'b110, 3'b110,
                                       3'b000, 3'b110, 3'b110, 3'b001, 3'b010};
        logic [31:0] vecRedir [10] = '{32'h120, 32'h104, 32'h104, 32'h120, 32'h120,
                                       32'h104, 32'h120, 32'h120, 32'h104, 32'h104};
        bit accepted;
        bit seen;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecA[i], vecB[i], vecFunc[i], 32'h100, 32'h20, vecPred[i], 32'h120, accepted);
            waitOutValid(seen);
            checkCount++;
            if (!(accepted && seen)) $display("[TB] FAIL cmp%0d_handshake: got acc=%b seen=%b expected 1/1", i, accepted, seen);
            else passCount++;
            checkCount++;
            if ({b2.out_taken, b2.out_mispredict, b2.out_illegal} !== vecFlags[i])
                $display("[TB] FAIL cmp%0d_flags: got %b%b%b expected %b", i, b2.out_taken,
                         b2.out_mispredict, b2.out_illegal, vecFlags[i]);
            else passCount++;
            checkCount++;
            if (b2.out_redirect_pc !== vecRedir[i])
                $display("[TB] FAIL cmp%0d_redirect: got %h expected %h", i, b2.out_redirect_pc, vecRedir[i]);
            else passCount++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        bit accepted;
        bit seen;
        doReset();
        applyStimulus(32'd0, 32'd0, 3'b110, 32'h1000, 32'hFFFFFFF0, 1, 32'h0FF0, accepted);
        waitOutValid(seen);
        checkCount++;
        if (!(accepted && seen)) $display("[TB] FAIL redir_hit_handshake: got acc=%b seen=%b expected 1/1", accepted, seen);
        else passCount++;
        checkCount++;
        if ({b2.out_redirect_pc, b2.out_taken, b2.out_mispredict} !== {32'h0FF0, 2'b10})
            $display("[TB] FAIL redir_hit: got %h/%b%b expected 00000ff0/10", b2.out_redirect_pc,
                     b2.out_taken, b2.out_mispredict);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (b2.mispredict_cnt !== 2'd0) $display("[TB] FAIL redir_hit_cnt: got %0d expected 0", b2.mispredict_cnt);
        else passCount++;
        applyStimulus(32'd0, 32'd0, 3'b110, 32'h1000, 32'hFFFFFFF0, 1, 32'h1004, accepted);
        waitOutValid(seen);
        checkCount++;
        if ({accepted, seen, b2.out_redirect_pc, b2.out_mispredict} !== {2'b11, 32'h0FF0, 1'b1})
            $display("[TB] FAIL redir_miss: got %b%b/%h/%b expected 11/00000ff0/1", accepted, seen,
                     b2.out_redirect_pc, b2.out_mispredict);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (b2.mispredict_cnt !== 2'd1) $display("[TB] FAIL redir_miss_cnt: got %0d expected 1", b2.mispredict_cnt);
        else passCount++;
    endtask

    task automatic test_wrap();
        bit accepted;
        bit seen;
        applyStimulus(32'd1, 32'd2, 3'b000, 32'hFFFFFFFC, 32'h8, 0, 32'h1234, accepted);
        waitOutValid(seen);
        checkCount++;
        if ({accepted, seen, b2.out_redirect_pc} !== {2'b11, 32'h0})
            $display("[TB] FAIL wrap_redirect: got %b%b/%h expected 11/00000000", accepted, seen, b2.out_redirect_pc);
        else passCount++;
        checkCount++;
        if ({b2.out_taken, b2.out_mispredict} !== 2'b00)
            $display("[TB] FAIL wrap_flags: got %b%b expected 00", b2.out_taken, b2.out_mispredict);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if (b2.mispredict_cnt !== 2'd1) $display("[TB] FAIL wrap_cnt: got %0d expected 1", b2.mispredict_cnt);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs  [4] = '{32'h2000, 32'h3000, 32'h4000, 32'h5000};
        logic [31:0] imms [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
        logic [31:0] tgts [4] = '{32'h2010, 32'h3020, 32'h4030, 32'h5040};
        int acc = 0;
        b2.out_ready = 0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 4) setReq(32'd0, 32'd0, 3'b110, pcs[acc], imms[acc], 1, tgts[acc]);
            else b2.in_valid = 0;
            #1;
            if (b2.in_valid && b2.in_ready) acc++;
            @(posedge clk); #1;
        end
        checkCount++;
        if (acc !== 2) $display("[TB] FAIL bp_accepted: got %0d expected 2", acc);
        else passCount++;
        checkCount++;
        if ({b2.in_ready, b2.out_valid} !== 2'b01)
            $display("[TB] FAIL bp_full: got in_ready=%b out_valid=%b expected 0/1", b2.in_ready, b2.out_valid);
        else passCount++;
        checkCount++;
        if (b2.out_redirect_pc !== 32'h2010) $display("[TB] FAIL bp_stable: got %h expected 00002010", b2.out_redirect_pc);
        else passCount++;
        b2.out_ready = 1;
        #1;
        checkCount++;
        if (b2.in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", b2.in_ready);
        else passCount++;
        @(posedge clk); #1;
        b2.in_valid = 0;
        checkCount++;
        if ({b2.out_valid, b2.out_redirect_pc} !== {1'b1, 32'h3020})
            $display("[TB] FAIL bp_second: got %b/%h expected 1/00003020", b2.out_valid, b2.out_redirect_pc);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if ({b2.out_valid, b2.out_redirect_pc} !== {1'b1, 32'h4030})
            $display("[TB] FAIL bp_third: got %b/%h expected 1/00004030", b2.out_valid, b2.out_redirect_pc);
        else passCount++;
        @(posedge clk); #1;
        checkCount++;
        if ({b2.out_valid, b2.mispredict_cnt} !== {1'b0, 2'd1})
            $display("[TB] FAIL bp_drain: got %b/%0d expected 0/1", b2.out_valid, b2.mispredict_cnt);
        else passCount++;
    endtask

    task automatic test_flush();
        bit acc0;
        bit acc1;
        doReset();
        b2.out_ready = 0;
        applyStimulus(32'd0, 32'd0, 3'b110, 32'h100, 32'h10, 0, 32'h0, acc0);
        applyStimulus(32'd0, 32'd0, 3'b110, 32'h200, 32'h10, 0, 32'h0, acc1);
        setReq(32'd0, 32'd0, 3'b110, 32'h300, 32'h10, 0, 32'h0);
        b2.flush = 1;
        b2.out_ready = 1;
        #1;
        checkCount++;
        if ({acc0, acc1, b2.out_valid, b2.out_mispredict} !== 4'b1111)
            $display("[TB] FAIL flush_setup: got %b%b%b%b expected 1111", acc0, acc1, b2.out_valid, b2.out_mispredict);
        else passCount++;
        checkCount++;
        if (b2.in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready: got %b expected 0", b2.in_ready);
        else passCount++;
        @(posedge clk); #1;
        b2.flush = 0;
        b2.in_valid = 0;
        checkCount++;
        if ({b2.out_valid, b2.mispredict_cnt} !== {1'b0, 2'd0})
            $display("[TB] FAIL flush_cleared: got %b/%0d expected 0/0", b2.out_valid, b2.mispredict_cnt);
        else passCount++;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({b2.out_valid, b2.mispredict_cnt} !== {1'b0, 2'd0})
            $display("[TB] FAIL flush_dropped: got %b/%0d expected 0/0", b2.out_valid, b2.mispredict_cnt);
        else passCount++;
    endtask

    task automatic test_saturation();
        int acc = 0;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            setReq(32'd0, 32'd0, 3'b110, 32'h500 + 32'(acc * 16), 32'h8, 0, 32'h0);
            #1;
            if (b2.in_ready) acc++;
            @(posedge clk); #1;
        end
        b2.in_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        checkCount++;
        if (acc !== 5) $display("[TB] FAIL sat_accepted: got %0d expected 5", acc);
        else passCount++;
        checkCount++;
        if (b2.mispredict_cnt !== 2'd3) $display("[TB] FAIL sat_cnt: got %0d expected 3", b2.mispredict_cnt);
        else passCount++;
    endtask

    task automatic test_async_reset();
        setReq(32'd0, 32'd0, 3'b110, 32'h600, 32'h8, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({b2.out_valid, b2.mispredict_cnt} !== {1'b1, 2'd3})
            $display("[TB] FAIL areset_pre: got %b/%0d expected 1/3", b2.out_valid, b2.mispredict_cnt);
        else passCount++;
        #2;
        rst_n = 0;
        #1;
        checkCount++;
        if ({b2.out_valid, b2.mispredict_cnt, b2.out_redirect_pc} !== {1'b1 ^ 1'b1, 2'd0, 32'h0})
            $display("[TB] FAIL areset_immediate: got %b/%0d/%h expected 0/0/00000000", b2.out_valid,
                     b2.mispredict_cnt, b2.out_redirect_pc);
        else passCount++;
        b2.in_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        checkCount++;
        if ({b2.out_valid, b2.mispredict_cnt} !== {1'b0, 2'd0})
            $display("[TB] FAIL areset_discard: got %b/%0d expected 0/0", b2.out_valid, b2.mispredict_cnt);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_stage1();
        test_compare();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
